// File: rtl/gpi_debounce_if.sv
// rtl/gpi_debounce_if.sv - pad-side enable/level inputs and debounced level/edge outputs
interface gpi_debounce_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] pin_in;
    logic [WIDTH-1:0] gpi_clean;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             tick;

    modport master (
        output en,
        output pin_in,
        input  gpi_clean,
        input  rise,
        input  fall,
        input  tick
    );

    modport slave (
        input  en,
        input  pin_in,
        output gpi_clean,
        output rise,
        output fall,
        output tick
    );
endinterface

// File: rtl/gpi_debounce.sv
// rtl/gpi_debounce.sv - per-bit synchronizer and tick-sampled debounce filter with edge pulses
module gpi_debounce #(
    parameter int WIDTH          = 8,
    parameter int TICK_DIV       = 1000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic PCLK,
    input  logic PRESET,
    gpi_debounce_if.slave bus
);
    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PRE_ONE   = PW'(1);
    localparam logic [4:0]      ACCEPT_AT = 5'(STABLE_SAMPLES);

    logic [WIDTH-1:0]      sync1, sync2;
    logic [PW-1:0]         pre_q, pre_d;
    logic [WIDTH-1:0][3:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]      clean_q, clean_d;
    logic [WIDTH-1:0]      rise_q, rise_d;
    logic [WIDTH-1:0]      fall_q, fall_d;
    logic                  tick;

    assign tick = bus.en && (pre_q == PRE_LAST);

    always_comb begin
        pre_d = '0;
        if (bus.en) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_ONE;
        end
    end

    // cnt == 0 is the STABLE state, anything else is PENDING toward a new level
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (!bus.en) begin
                cnt_d[b] = 4'd0;
            end else if (tick) begin
                if (sync2[b] == clean_q[b]) begin
                    cnt_d[b] = 4'd0;
                end else if (({1'b0, cnt_q[b]} + 5'd1) < ACCEPT_AT) begin
                    cnt_d[b] = cnt_q[b] + 4'd1;
                end else begin
                    cnt_d[b]   = 4'd0;
                    clean_d[b] = sync2[b];
                    rise_d[b]  = sync2[b];
                    fall_d[b]  = ~sync2[b];
                end
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync1   <= '0;
            sync2   <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            sync1   <= bus.pin_in;
            sync2   <= sync1;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign bus.gpi_clean = clean_q;
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
    assign bus.tick      = tick;
endmodule

// File: tb/tb_gpi_debounce.sv
// tb/tb_gpi_debounce.sv - scoreboard bench for gpi_debounce against a sample-window reference model
module tb_gpi_debounce;
    localparam int W  = 8;
    localparam int TD = 4;
    localparam int SS = 3;

    logic PCLK = 1'b0;
    logic PRESET;

    gpi_debounce_if #(.WIDTH(W)) bus ();

    gpi_debounce #(
        .WIDTH(W),
        .TICK_DIV(TD),
        .STABLE_SAMPLES(SS)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .bus(bus)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         tick;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference: the filter accepts a bit once the last SS tick samples all disagree with it.
    logic [W-1:0] m_clean;
    logic [W-1:0] m_pin_1ago;
    logic [W-1:0] m_pin_2ago;
    int           m_en_cycles;
    logic [W-1:0] m_samples[$];

    task automatic model_step(input logic [W-1:0] p, input logic e, input logic r);
        exp_t         x;
        logic [W-1:0] rs;
        logic [W-1:0] fs;
        logic [W-1:0] seen;
        logic         all_diff;
        rs   = '0;
        fs   = '0;
        seen = m_pin_2ago;
        if (r) begin
            m_clean     = '0;
            m_en_cycles = 0;
            m_samples.delete();
            m_pin_1ago  = '0;
            m_pin_2ago  = '0;
        end else begin
            if (!e) begin
                m_en_cycles = 0;
                m_samples.delete();
            end else begin
                if ((m_en_cycles % TD) == TD - 1) begin
                    m_samples.push_back(seen);
                    if (m_samples.size() > SS) void'(m_samples.pop_front());
                    if (m_samples.size() == SS) begin
                        for (int b = 0; b < W; b++) begin
                            all_diff = 1'b1;
                            for (int i = 0; i < SS; i++)
                                if (m_samples[i][b] == m_clean[b]) all_diff = 1'b0;
                            if (all_diff) begin
                                rs[b] = ~m_clean[b];
                                fs[b] = m_clean[b];
                                m_clean[b] = ~m_clean[b];
                            end
                        end
                    end
                end
                m_en_cycles++;
            end
            m_pin_2ago = m_pin_1ago;
            m_pin_1ago = p;
        end
        x.clean = m_clean;
        x.rise  = rs;
        x.fall  = fs;
        x.tick  = e && !r && ((m_en_cycles % TD) == TD - 1);
        exp_q.push_back(x);
    endtask

    task automatic step(input logic [W-1:0] p, input logic e, input logic r);
        @(negedge PCLK);
        bus.pin_in = p;
        bus.en     = e;
        PRESET     = r;
        model_step(p, e, r);
        @(posedge PCLK);
        #2;
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        tests++;
        if (got < lo || got > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    always @(posedge PCLK) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (bus.gpi_clean !== e.clean || bus.rise !== e.rise ||
                bus.fall !== e.fall || bus.tick !== e.tick) begin
                fails++;
                $display("FAIL scoreboard t=%0t: clean/rise/fall/tick got %h/%h/%h/%b expected %h/%h/%h/%b",
                         $time, bus.gpi_clean, bus.rise, bus.fall, bus.tick,
                         e.clean, e.rise, e.fall, e.tick);
            end
        end
    end

    initial begin
        int           n;
        int           cnt;
        int           len;
        int           kind;
        logic [W-1:0] cur;
        logic         cur_en;

        PRESET      = 1'b1;
        bus.en      = 1'b0;
        bus.pin_in  = '0;
        m_clean     = '0;
        m_pin_1ago  = '0;
        m_pin_2ago  = '0;
        m_en_cycles = 0;

        repeat (3) step(8'hFF, 1'b1, 1'b1);
        check("reset_state", int'({bus.gpi_clean, bus.rise, bus.fall, bus.tick}), 0);
        repeat (20) step(8'h00, 1'b1, 1'b0);

        n = 0;
        do begin
            step(8'h01, 1'b1, 1'b0);
            n++;
        end while (!bus.gpi_clean[0] && n < 30);
        check_range("clean_edge_latency", n, 11, 14);
        check("clean_edge_rise", int'(bus.rise), 8'h01);
        step(8'h01, 1'b1, 1'b0);
        check("clean_edge_rise_one_cycle", int'(bus.rise), 0);
        repeat (10) step(8'h01, 1'b1, 1'b0);

        repeat (6) step(8'h09, 1'b1, 1'b0);
        repeat (20) step(8'h01, 1'b1, 1'b0);
        check("glitch_rejected", int'(bus.gpi_clean), 8'h01);

        repeat (20) step(8'h00, 1'b1, 1'b0);
        cnt = 0;
        for (int j = 0; j < 20; j++) begin
            step(8'hA5, 1'b1, 1'b0);
            if (bus.rise == 8'hA5) cnt++;
        end
        check("simul_rise_once", cnt, 1);
        check("simul_clean", int'(bus.gpi_clean), 8'hA5);
        cnt = 0;
        for (int j = 0; j < 20; j++) begin
            step(8'h00, 1'b1, 1'b0);
            if (bus.fall == 8'hA5) cnt++;
        end
        check("simul_fall_once", cnt, 1);

        cnt = 0;
        for (int j = 0; j < 50; j++) begin
            step(8'h02, 1'b0, 1'b0);
            if (bus.tick || bus.rise != 0 || bus.gpi_clean[1]) cnt++;
        end
        check("freeze_quiet", cnt, 0);
        n = 0;
        do begin
            step(8'h02, 1'b1, 1'b0);
            n++;
        end while (!bus.gpi_clean[1] && n < 30);
        check_range("freeze_release_latency", n, 9, 14);

        repeat (20) step(8'h00, 1'b1, 1'b0);
        repeat (3) step(8'h04, 1'b0, 1'b0);
        repeat (9) step(8'h04, 1'b1, 1'b0);
        repeat (2) step(8'h04, 1'b1, 1'b1);
        check("midpend_reset_clean", int'(bus.gpi_clean), 0);
        n = 0;
        do begin
            step(8'h04, 1'b1, 1'b0);
            n++;
        end while (!bus.gpi_clean[2] && n < 30);
        check_range("midpend_requalify_latency", n, 9, 14);

        cur    = 8'h04;
        cur_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            len  = $urandom_range(1, 24);
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                repeat (2) step(cur, cur_en, 1'b1);
            end else if (kind < 3) begin
                cur_en = ~cur_en;
            end else begin
                cur    = cur ^ (W'($urandom) & W'($urandom));
                cur_en = 1'b1;
            end
            for (int j = 0; j < len; j++) step(cur, cur_en, 1'b0);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
